// File: rtl/ela_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : ela_pkg                                                      |
// | Description : Shared constants for the ELA frame-memory slice.             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package ela_pkg;

    localparam int IMG_W    = 128;
    localparam int IMG_H    = 64;
    localparam int AW       = $clog2(IMG_W * IMG_H);
    localparam int DW       = 8;

    localparam int REQ_LOAD = 0;
    localparam int REQ_ELA  = 1;
    localparam int REQ_HOST = 2;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 1'b0;
    localparam arb_state_t ST_OWNED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ela_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ela_rr_pick                                                  |
// | Description : Combinational round-robin picker, search starts at last+1.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ela_rr_pick #(
    parameter int N_REQ = 3,
    parameter int LW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [LW-1:0]    last,
    output logic [N_REQ-1:0] win
);
    import ela_pkg::*;

    logic [LW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        win     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = LW'((int'(last) + i) % N_REQ);
            if (!w_found && req[w_idx]) begin
                win[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ela_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ela_mem_arbiter                                              |
// | Description : Round-robin arbiter with burst lock for the ELA frame memory.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ela_mem_arbiter #(
    parameter int N_REQ     = 3,
    parameter int AW        = ela_pkg::AW,
    parameter int DW        = ela_pkg::DW,
    parameter int BURST_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    lock,
    input  logic [N_REQ-1:0]    wen,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic                mem_wen,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata
);
    import ela_pkg::*;

    localparam int LW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BCW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [BCW-1:0] c_burst_last = BCW'(BURST_MAX - 1);
    localparam logic [BCW-1:0] c_burst_one  = (BURST_MAX > 1) ? BCW'(1) : '0;
    localparam logic [LW-1:0]  c_last_rst   = LW'(N_REQ - 1);

    arb_state_t       r_state, w_state_nxt;
    logic [LW-1:0]    r_owner, w_owner_nxt;
    logic [LW-1:0]    r_last, w_last_nxt;
    logic [BCW-1:0]   r_burst_cnt, w_burst_nxt;
    logic [N_REQ-1:0] w_win, w_owner_oh;
    logic [LW-1:0]    w_win_idx, w_sel_idx, r_tag_idx;
    logic             w_hold, w_others, w_accept, w_sel_wen, r_tag_vld;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_wdata;

    ela_rr_pick #(
        .N_REQ (N_REQ),
        .LW    (LW)
    ) u_pick (
        .req  (req),
        .last (r_last),
        .win  (w_win)
    );

    assign w_owner_oh = N_REQ'(1) << r_owner;
    assign w_hold     = (r_state == ST_OWNED) && req[r_owner] && lock[r_owner];
    assign w_others   = |(req & ~w_owner_oh);
    assign w_accept   = |gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_last      <= c_last_rst;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_burst_nxt = r_burst_cnt;
        if (w_hold) begin
            // The beat at the burst limit is still granted; rotation happens after it.
            if (r_burst_cnt == c_burst_last) begin
                w_burst_nxt = '0;
                if (w_others) begin
                    w_state_nxt = ST_IDLE;
                end
            end else begin
                w_burst_nxt = r_burst_cnt + 1'b1;
            end
        end else begin
            w_state_nxt = ST_IDLE;
            w_burst_nxt = '0;
            if (|w_win) begin
                w_last_nxt = w_win_idx;
                if (|(w_win & lock)) begin
                    w_state_nxt = ST_OWNED;
                    w_owner_nxt = w_win_idx;
                    w_burst_nxt = c_burst_one;
                end
            end
        end
    end

    always_comb begin
        gnt = w_hold ? w_owner_oh : w_win;
    end

    always_comb begin
        w_win_idx   = '0;
        w_sel_idx   = '0;
        w_sel_wen   = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_win[k]) begin
                w_win_idx = LW'(k);
            end
            if (gnt[k]) begin
                w_sel_idx   = LW'(k);
                w_sel_wen   = wen[k];
                w_sel_addr  = addr[k*AW +: AW];
                w_sel_wdata = wdata[k*DW +: DW];
            end
        end
    end

    // Command bus plus a two-stage read tag: stage one tracks the memory cycle, rvalid is stage two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r_tag_vld <= 1'b0;
            r_tag_idx <= '0;
            rvalid    <= '0;
            rdata     <= '0;
        end else begin
            mem_wen   <= w_accept & w_sel_wen;
            if (w_accept) begin
                mem_addr  <= w_sel_addr;
                mem_wdata <= w_sel_wdata;
            end
            r_tag_vld <= w_accept & ~w_sel_wen;
            r_tag_idx <= w_sel_idx;
            rvalid    <= r_tag_vld ? (N_REQ'(1) << r_tag_idx) : '0;
            if (r_tag_vld) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ela_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ela_mem_arbiter                                           |
// | Description : Directed bench with read scoreboard for ela_mem_arbiter.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_ela_mem_arbiter;
    import ela_pkg::*;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, lock, wen;
    logic [N*13-1:0] addr;
    logic [N*8-1:0]  wdata;
    logic [N-1:0]  gnt, rvalid;
    logic [7:0]    rdata, mem_wdata, mem_rdata;
    logic          mem_wen;
    logic [12:0]   mem_addr;

    logic [7:0] mem    [0:8191];
    logic [7:0] shadow [0:8191];

    typedef struct {
        int         due;
        int         idx;
        logic [7:0] data;
    } sb_t;
    sb_t sb[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    ela_mem_arbiter u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .wen       (wen),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [12:0] a, input logic [7:0] d);
        addr[k*13 +: 13] = a;
        wdata[k*8 +: 8]  = d;
    endtask

    // Called just after a falling edge with inputs set; returns this cycle's grant.
    task automatic tick(output logic [N-1:0] g);
        logic [N-1:0] exp_rv;
        logic [12:0]  a;
        sb_t          e;
        #1;
        g = gnt;
        for (int k = 0; k < N; k++) begin
            a = addr[k*13 +: 13];
            if (g[k] && !wen[k]) sb.push_back('{due: cyc + 2, idx: k, data: shadow[a]});
            if (g[k] && wen[k])  shadow[a] = wdata[k*8 +: 8];
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        exp_rv = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            exp_rv[e.idx] = 1'b1;
            chk("rdata", {24'd0, rdata}, {24'd0, e.data});
        end
        chk("rvalid", {29'd0, rvalid}, {29'd0, exp_rv});
    endtask

    initial begin
        logic [N-1:0] g;
        for (int i = 0; i < 8192; i++) begin
            mem[i]    = i[7:0] ^ 8'hA5;
            shadow[i] = i[7:0] ^ 8'hA5;
        end
        mem[13'h0080]    = 8'h5A;
        shadow[13'h0080] = 8'h5A;

        rst = 1'b1; req = '0; lock = '0; wen = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",       {29'd0, gnt},      0);
        chk("rst_rvalid",    {29'd0, rvalid},   0);
        chk("rst_rdata",     {24'd0, rdata},    0);
        chk("rst_mem_wen",   {31'd0, mem_wen},  0);
        chk("rst_mem_addr",  {19'd0, mem_addr}, 0);
        chk("rst_mem_wdata", {24'd0, mem_wdata},0);
        rst = 1'b0;

        // Single host read
        req = 3'b100; set_req(REQ_HOST, 13'h0080, 8'h00);
        tick(g);
        chk("t1_gnt", {29'd0, g}, 32'h4);
        chk("t1_mem_addr", {19'd0, mem_addr}, 32'h80);
        chk("t1_mem_wen", {31'd0, mem_wen}, 0);
        req = '0;
        tick(g);
        chk("t1_rdata", {24'd0, rdata}, 32'h5A);
        chk("t1_idle_gnt", {29'd0, g}, 0);

        // All three requesting, unlocked
        req = 3'b111;
        set_req(REQ_LOAD, 13'h0010, 8'h00);
        set_req(REQ_ELA,  13'h0020, 8'h00);
        set_req(REQ_HOST, 13'h0030, 8'h00);
        for (int i = 0; i < 6; i++) begin
            tick(g);
            chk("t2_rr_gnt", {29'd0, g}, 32'd1 << (i % 3));
        end
        req = '0;
        repeat (2) tick(g);

        // Locked engine burst of five reads with loader pending
        req = 3'b010; lock = 3'b010;
        for (int i = 0; i < 5; i++) begin
            set_req(REQ_ELA, 13'(13'h0200 + i), 8'h00);
            tick(g);
            chk("t3_lock_gnt", {29'd0, g}, 32'h2);
            req = 3'b011;
        end
        req = 3'b001; lock = '0;
        set_req(REQ_LOAD, 13'h0300, 8'h00);
        tick(g);
        chk("t3_after_gnt", {29'd0, g}, 32'h1);
        req = '0;
        repeat (2) tick(g);

        // Burst limit with host pending
        req = 3'b110; lock = 3'b010;
        for (int i = 0; i < 20; i++) begin
            tick(g);
            chk("t4_burst_gnt", {29'd0, g}, ((i % 9) < 8) ? 32'h2 : 32'h4);
        end
        req = '0; lock = '0;
        repeat (2) tick(g);

        // Write then read to the same address
        req = 3'b001; wen = 3'b001; set_req(REQ_LOAD, 13'h1FBF, 8'h33);
        tick(g);
        chk("t5_wr_gnt", {29'd0, g}, 32'h1);
        chk("t5_mem_wen", {31'd0, mem_wen}, 1);
        chk("t5_mem_addr", {19'd0, mem_addr}, 32'h1FBF);
        chk("t5_mem_wdata", {24'd0, mem_wdata}, 32'h33);
        wen = '0;
        tick(g);
        chk("t5_rd_gnt", {29'd0, g}, 32'h1);
        req = '0;
        repeat (2) tick(g);
        chk("t5_rdata", {24'd0, rdata}, 32'h33);

        // Reset in the cycle after a read grant
        req = 3'b001; set_req(REQ_LOAD, 13'h0100, 8'h00);
        tick(g);
        chk("t6_gnt", {29'd0, g}, 32'h1);
        req = '0;
        rst = 1'b1;
        #1;
        chk("t6_gnt0",      {29'd0, gnt},       0);
        chk("t6_rvalid0",   {29'd0, rvalid},    0);
        chk("t6_rdata0",    {24'd0, rdata},     0);
        chk("t6_mem_wen0",  {31'd0, mem_wen},   0);
        chk("t6_mem_addr0", {19'd0, mem_addr},  0);
        chk("t6_mem_wdata0",{24'd0, mem_wdata}, 0);
        #1;
        rst = 1'b0;
        sb.delete();
        tick(g);
        req = 3'b111;
        tick(g);
        chk("t6_first_gnt", {29'd0, g}, 32'h1);
        req = '0;
        repeat (2) tick(g);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
